disp_88_feeder: RTL
===================

# disp_88_feeder

Upstream feeder for the 8-page, two-digit 8-segment display sender. It snapshots eight 8-bit page values on a load strobe and converts each to two display nibbles in the background: binary to two-digit BCD, or raw hex per page. It commits all pages atomically to a display buffer. The sender's `addr` indexes that buffer to drive `dain`/`dp` with zero latency, and the sender's `scanp` paces overflow blinking.

## Interface
Parameters:
- `HEX_MASK`, default 8'h00: bit i = 1 means page i is shown as raw hex; 0 means two-digit decimal.
- `BLINK_LOG2`, default 3: the blink phase toggles every 2^BLINK_LOG2 `scanp` pulses. Range 1..7.

Ports:
- `clk2m`, in, 1: system clock (2 MHz). One clock only.
- `nrst`, in, 1: asynchronous, active-low reset.
- `page_data`, in, 64: page i occupies bits [8i+7:8i]. Unsigned binary.
- `load`, in, 1: single-cycle request to snapshot and convert all pages.
- `addr`, in, 3: page select from the sender.
- `scanp`, in, 1: scan pulse from the sender, one cycle wide.
- `dain`, out, 8: {tens/high nibble, ones/low nibble} of page `addr`.
- `dp`, out, 2: decimal points; used as the overflow blink indicator.
- `busy`, out, 1: conversion in progress.

## Operation
- **Registers**
  - Snapshot: 64 b.
  - Shadow buffer: 8×8 b result, plus 8×1 b overflow.
  - Display buffer: 8×8 b, plus 8×1 b overflow.
  - Double-dabble work register: 12 b BCD plus 8 b shift.
  - Page counter: 3 b.
  - Bit counter: 3 b.
  - Pending flag.
  - Blink counter and blink phase.
- **FSM states:** IDLE, CONV, COMMIT.
  - IDLE → CONV when `load` = 1 or pending = 1. At this transition: snapshot ← `page_data`, page ← 0, pending ← 0.
  - CONV, hex page (HEX_MASK[page] = 1): 1 cycle. Shadow[page] ← byte, ovf ← 0.
  - CONV, decimal page: 8 cycles of shift-add-3, one bit per cycle, MSB first. Shadow[page] ← {tens, ones} of the BCD result. Ovf ← (byte > 99), evaluated in binary.
  - After page 7 completes → COMMIT.
  - COMMIT, 1 cycle. Display buffer ← shadow; display ovf ← shadow ovf. Then go to CONV if pending (the new snapshot is taken at this edge, page ← 0, pending ← 0), else IDLE.
- **Load during CONV or COMMIT:** sets pending. Multiple loads collapse to one. `page_data` is sampled at restart, not at the time of the request.
- **Output mapping:**
  - `dain` = display[addr], except ovf[addr] = 1 gives 8'hEE.
  - `dp` = {2{blink_phase & ovf[addr]}}.
  - Both are purely combinational from registers and `addr`.
- **Blink:** the counter increments on each `scanp`. When it wraps, blink_phase toggles. The counter runs free regardless of FSM state.
- **Display contents:** change only at the COMMIT edge. Pages are never shown half-converted or mixed between snapshots.

## Timing
- **Reset values:** FSM IDLE; all buffers 0; ovf 0; pending 0; blink counter and phase 0. So `dain` = 8'h00, `dp` = 2'b00, `busy` = 0.
- **Reset mid-conversion:** everything clears, the display buffer included. Nothing from the aborted conversion commits.
- **`busy`:** registered. It rises on the edge that samples `load` in IDLE and falls on the COMMIT exit edge. It stays high continuously across a pending restart.
- **Latency, load sample to display update:** (8 × number of decimal pages) + (number of hex pages) + 1 cycles.
  - All decimal: 65 cycles.
  - All hex: 9 cycles.
- **`addr` to `dain`/`dp`:** 0 cycles. The sender loads its shift register at the end of the first cycle after `addr` changes, and `dain` must already reflect the new `addr` by then.
- **Boundary values:**
  - 99 → 8'h99, no overflow.
  - 100 → overflow.
  - 255 → overflow.
  - 0 → 8'h00.
- **Simultaneous events:**
  - `load` in the COMMIT cycle sets pending and the restart occurs at that same edge, using the current `page_data`.
  - `scanp` coincident with COMMIT: blink and commit are independent.

## Test plan
- Reset with `load` idle → `dain` = 00 and `dp` = 00 for every `addr`, `busy` = 0.
- Page0 = 57, page7 = 9, default mask, `load` pulse → `busy` high for exactly 65 cycles. `dain` stays 00 meanwhile. Afterwards addr0 → 8'h57, addr7 → 8'h09.
- HEX_MASK = 8'h08, page3 = 8'hA7, `load` → `busy` 58 cycles, then addr3 → 8'hA7 with `dp` = 00.
- Page5 = 100, page6 = 99, BLINK_LOG2 = 3 → addr5: `dain` = EE, `dp` alternates 00/11 every 8 `scanp` pulses. Addr6: `dain` = 99, `dp` constant 00.
- `load` at cycle 10 of a conversion, `page_data` changed before COMMIT → `busy` stays high across the restart. The first commit shows the old data, and the second commit, 65 cycles later, shows the new data.
- `nrst` asserted at cycle 30 of a conversion, after a prior commit of 8'h42 on addr0 → `dain` = 00 immediately and `busy` = 0. No commit follows `nrst` deassertion.

Source files
------------

// File: rtl/disp_88_feeder.sv
// Snapshot eight page bytes on load, convert each to two display nibbles
// (double-dabble BCD or raw hex), and commit all pages atomically.
module disp_88_feeder #(
  parameter logic [7:0]  HEX_MASK   = 8'h00,
  parameter int unsigned BLINK_LOG2 = 3
) (
  input  logic        clk2m,
  input  logic        nrst,
  input  logic [63:0] page_data,
  input  logic        load,
  input  logic [2:0]  addr,
  input  logic        scanp,
  output logic [7:0]  dain,
  output logic [1:0]  dp,
  output logic        busy
);

  localparam int unsigned NPAGE = 8;
  localparam int unsigned BW    = BLINK_LOG2;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CONV,
    S_COMMIT
  } state_e;

  state_e          state_q;
  logic [63:0]     snap_q;
  logic [7:0]      shadow_q     [NPAGE];
  logic [7:0]      shadow_ovf_q;
  logic [7:0]      disp_q       [NPAGE];
  logic [7:0]      disp_ovf_q;
  logic [11:0]     bcd_q;
  logic [7:0]      sh_q;
  logic [2:0]      page_q;
  logic [2:0]      bit_q;
  logic            pending_q;
  logic            busy_q;
  logic [BW-1:0]   blink_cnt_q;
  logic            blink_phase_q;

  logic [7:0]      cur_byte;
  logic            is_hex;
  logic            page_done;
  logic            restart;
  logic [11:0]     adj;
  logic [7:0]      sh_in;
  logic [11:0]     bcd_d;
  logic [7:0]      sh_d;

  assign cur_byte  = snap_q[{page_q, 3'b000} +: 8];
  assign is_hex    = HEX_MASK[page_q];
  assign page_done = is_hex | (bit_q == 3'd7);
  assign restart   = load | pending_q;

  // One double-dabble step; bit 0 of each page starts from a fresh work register.
  always_comb begin
    adj   = (bit_q == 3'd0) ? 12'd0 : bcd_q;
    sh_in = (bit_q == 3'd0) ? cur_byte : sh_q;
    for (int i = 0; i < 3; i++) begin
      if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
    end
    {bcd_d, sh_d} = {adj, sh_in} << 1;
  end

  always_ff @(posedge clk2m or negedge nrst) begin
    if (!nrst) begin
      state_q      <= S_IDLE;
      snap_q       <= '0;
      shadow_ovf_q <= '0;
      disp_ovf_q   <= '0;
      bcd_q        <= '0;
      sh_q         <= '0;
      page_q       <= '0;
      bit_q        <= '0;
      pending_q    <= 1'b0;
      busy_q       <= 1'b0;
      for (int i = 0; i < NPAGE; i++) begin
        shadow_q[i] <= '0;
        disp_q[i]   <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (restart) begin
            snap_q    <= page_data;
            page_q    <= '0;
            bit_q     <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_CONV;
          end
        end
        S_CONV: begin
          if (load) pending_q <= 1'b1;
          if (is_hex) begin
            shadow_q[page_q]     <= cur_byte;
            shadow_ovf_q[page_q] <= 1'b0;
          end else begin
            bcd_q <= bcd_d;
            sh_q  <= sh_d;
            if (bit_q == 3'd7) begin
              shadow_q[page_q]     <= bcd_d[7:0];
              shadow_ovf_q[page_q] <= (cur_byte > 8'd99);
            end
          end
          if (page_done) begin
            bit_q <= '0;
            if (page_q == 3'd7) state_q <= S_COMMIT;
            else                page_q  <= page_q + 3'd1;
          end else begin
            bit_q <= bit_q + 3'd1;
          end
        end
        S_COMMIT: begin
          for (int i = 0; i < NPAGE; i++) disp_q[i] <= shadow_q[i];
          disp_ovf_q <= shadow_ovf_q;
          // A request seen during conversion or on this edge restarts immediately.
          if (restart) begin
            snap_q    <= page_data;
            page_q    <= '0;
            bit_q     <= '0;
            pending_q <= 1'b0;
            state_q   <= S_CONV;
          end else begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Free-running blink divider paced by the sender's scan pulse.
  always_ff @(posedge clk2m or negedge nrst) begin
    if (!nrst) begin
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
    end else if (scanp) begin
      blink_cnt_q <= blink_cnt_q + BW'(1);
      if (&blink_cnt_q) blink_phase_q <= ~blink_phase_q;
    end
  end

  assign busy = busy_q;

  always_comb begin
    dain = disp_ovf_q[addr] ? 8'hEE : disp_q[addr];
    dp   = {2{blink_phase_q & disp_ovf_q[addr]}};
  end

endmodule
